// File: rtl/mul_add_seq_pkg.sv
// Shared definitions for the multiply-add block and its neighbours in the
// RSA datapath (the divider wrapper and the RSA top import this as well).
//   DEF_WIDTH : default operand width
//   DEF_RES_W : matching result width (2*DEF_WIDTH)
//   state_t   : IDLE / RUN / DONE encoding of the multiply-add FSM
package mul_add_seq_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_RES_W = 2 * DEF_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_add_seq.sv
// Sequential constant-time multiply-add: p = q*b + r.
// Radix-2 shift-add, one multiplier bit per cycle, always WIDTH RUN cycles.
// Rebuilds a dividend from quotient/divisor/remainder; also the product
// stage of the RSA modular-exponentiation datapath.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   operand handshake; q, b, r sampled on accept only
//   out_valid/out_ready result handshake; p held stable until taken
//   p                   2*WIDTH-bit result
//   fits                upper half of p is zero
//   busy                FSM not in IDLE
module mul_add_seq
  import mul_add_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   q,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   r,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               fits,
  output logic               busy
);

  localparam int unsigned RW = 2 * WIDTH;

  state_t            state, state_nx;
  logic [RW-1:0]     acc, mcand, acc_nx;
  logic [WIDTH-1:0]  mplier;
  logic [CNT_W-1:0]  cnt;
  logic              accept, last;

  always_comb begin
    accept   = (state == IDLE) && in_valid && in_ready;
    last     = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
    // Partial-product add for the current multiplier bit; on the last RUN
    // cycle this is the final result, so it goes straight into p.
    acc_nx   = mplier[0] ? (acc + mcand) : acc;
    busy     = (state != IDLE);
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      p         <= '0;
      fits      <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc      <= {{WIDTH{1'b0}}, r};
            mcand    <= {{WIDTH{1'b0}}, b};
            mplier   <= q;
            cnt      <= '0;
            in_ready <= 1'b0;
          end else begin
            in_ready <= 1'b1;
          end
        end
        RUN: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last) begin
            p         <= acc_nx;
            fits      <= (acc_nx[RW-1:WIDTH] == '0);
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_add_seq.sv
module tb_mul_add_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] q, b, r;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] p;
  logic        fits;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mul_add_seq #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .q(q), .b(b), .r(r),
    .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .fits(fits), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for in_ready (bounded), present operands, pass the accept edge,
  // then scramble the inputs so any late sampling shows up in the result.
  task automatic start_op(input logic [15:0] qi, input logic [15:0] bi, input logic [15:0] ri);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_before_accept", in_ready, 1);
    q = qi; b = bi; r = ri; in_valid = 1'b1;
    tick();
    q = 16'($urandom); b = 16'($urandom); r = 16'($urandom);
    in_valid = 1'b0;
  endtask

  // Called in the first cycle after the accept edge (cycle 1).
  task automatic finish_op(input logic [15:0] qi, input logic [15:0] bi, input logic [15:0] ri,
                           input int hold, input bit check_lat);
    longint unsigned exp_p;
    logic            exp_fits;
    logic [31:0]     p_seen;
    int              n = 1;
    exp_p    = longint'(qi) * longint'(bi) + longint'(ri);
    exp_fits = (exp_p < 64'h1_0000);
    while (!out_valid && n < 40) begin
      if (n == 1) check("busy_in_run", busy, 1);
      // Handshake inputs outside their states must be ignored.
      out_ready = 1'($urandom);
      in_valid  = 1'($urandom);
      tick();
      n++;
    end
    in_valid = 1'b0;
    if (check_lat) check("latency", 64'(n), 17);
    check("out_valid", out_valid, 1);
    check("p", p, exp_p);
    check("fits", fits, exp_fits);
    check("in_ready_done", in_ready, 0);
    out_ready = 1'b0;
    p_seen = p;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_p", p, p_seen);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("drain_valid", out_valid, 0);
    check("drain_in_ready", in_ready, 1);
    check("drain_busy", busy, 0);
    check("p_kept_idle", p, exp_p);
  endtask

  task automatic do_op(input logic [15:0] qi, input logic [15:0] bi, input logic [15:0] ri,
                       input int hold, input bit check_lat);
    start_op(qi, bi, ri);
    finish_op(qi, bi, ri, hold, check_lat);
  endtask

  initial begin
    logic [15:0] a, dv;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    q = '0; b = '0; r = '0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_p", p, 0);
    check("rst_fits", fits, 0);
    check("rst_busy", busy, 0);
    tick();
    tick();
    check("rst_hold_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("in_ready_after_rst", in_ready, 1);

    // Directed cases.
    do_op(16'h1234, 16'h0010, 16'h0005, 0, 1);
    do_op(16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 1);
    do_op(16'h0000, 16'hABCD, 16'h0007, 0, 1);
    do_op(16'h0001, 16'h0001, 16'h0000, 0, 1);
    // Backpressure for 5 cycles.
    do_op(16'h00FF, 16'h0101, 16'h0002, 5, 1);

    // Reset in the middle of RUN.
    start_op(16'hBEEF, 16'h1234, 16'h5678);
    for (int i = 1; i < 8; i++) tick();
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_p", p, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("abort_in_ready_rise", in_ready, 1);
    do_op(16'hBEEF, 16'h1234, 16'h5678, 0, 1);

    // Reset while holding a finished result.
    start_op(16'h0303, 16'h0404, 16'h0505);
    for (int i = 1; i < 17; i++) tick();
    check("done_reached", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("abort_done_valid", out_valid, 0);
    check("abort_done_p", p, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Random operands with random backpressure.
    for (int i = 0; i < 100; i++)
      do_op(16'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1);

    // Round trip against an integer divider: dividend rebuilt exactly.
    for (int i = 0; i < 1000; i++) begin
      a  = 16'($urandom);
      dv = 16'($urandom_range(1, 65535));
      if (i % 4 == 0) dv = 16'($urandom_range(1, 255));
      do_op(a / dv, dv, a % dv, 0, 0);
      check("roundtrip_p", p, {48'b0, a});
      check("roundtrip_fits", fits, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
